// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: op encoding, FSM states,
// latency bound and op classification helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    LB, LBU, LH, LHU, LW, SB, SH, SW
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE, WAIT, DONE
  } state_t;

  localparam int MAX_READ_LATENCY = 4;
  localparam int CNT_W = $clog2(MAX_READ_LATENCY);

  function automatic logic is_load(input mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_half(input mem_op_t op);
    return op inside {LH, LHU, SH};
  endfunction

  function automatic logic is_word(input mem_op_t op);
    return op inside {LW, SW};
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load lane selection and sign/zero extension of a raw SRAM word.
// Purely combinational.
module load_extract
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = rdata[{off, 3'b000} +: 8];
  assign halfLane = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (op)
      LB:      data = {{24{byteLane[7]}}, byteLane};
      LBU:     data = {24'h0, byteLane};
      LH:      data = {{16{halfLane[15]}}, halfLane};
      LHU:     data = {16'h0, halfLane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage engine driving the data SRAM for loads and stores.
// Define MEM_ADDR_EXC_EN to trap misaligned accesses instead of masking.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  mem_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              stall_o,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(READ_LATENCY - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  mem_op_t          opQ;
  logic [1:0]       offQ;
  logic [31:0]      rdataQ;
  logic [31:0]      extData;

  logic       misaligned;
  logic       idleReq;
  logic       excReq;
  logic       accept;
  logic       loadGo;
  logic       storeGo;
  logic [1:0] off;
  logic [3:0] wenPat;
  logic [31:0] wdataRep;

  // Byte offset after forcing natural alignment for the access size.
  always_comb begin
    off = req_addr[1:0];
    if (is_word(req_op)) begin
      off = 2'b00;
    end else if (is_half(req_op)) begin
      off[0] = 1'b0;
    end
  end

`ifdef MEM_ADDR_EXC_EN
  assign misaligned =
    (is_half(req_op) & req_addr[0]) |
    (is_word(req_op) & (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign idleReq = ~reset & req_valid & (state == IDLE);
  assign excReq  = idleReq & misaligned;
  assign accept  = idleReq & ~flush & ~misaligned;
  assign loadGo  = accept & is_load(req_op);
  assign storeGo = accept & is_store(req_op);

  always_comb begin
    wenPat   = 4'b1111;
    wdataRep = req_wdata;
    unique case (1'b1)
      (req_op == SB): begin
        wenPat   = 4'b0001 << off;
        wdataRep = {4{req_wdata[7:0]}};
      end
      (req_op == SH): begin
        wenPat   = 4'b0011 << off;
        wdataRep = {2{req_wdata[15:0]}};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opQ    <= LB;
      offQ   <= '0;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (loadGo) begin
        opQ  <= req_op;
        offQ <= off;
      end
      if (state == WAIT && cnt == '0) begin
        rdataQ <= data_sram_rdata;
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (loadGo) begin
          stateNext = WAIT;
          cntNext   = CNT_INIT;
        end
      end
      WAIT: begin
        if (flush) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cnt == '0) begin
          stateNext = DONE;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  load_extract uExtract (
    .op    (opQ),
    .off   (offQ),
    .rdata (rdataQ),
    .data  (extData)
  );

  // Stall covers the request cycle and every WAIT cycle, not DONE.
  always_comb begin
    stall_o = loadGo |
      (~reset & ~flush & (state == WAIT));
    data_sram_en = loadGo | storeGo;
    data_sram_wen = storeGo ? wenPat : 4'b0000;
    data_sram_addr = data_sram_en ?
      {req_addr[ADDR_W-1:2], 2'b00} : '0;
    data_sram_wdata = storeGo ? wdataRep : '0;
    load_valid_o = ~reset & ~flush & (state == DONE);
    load_data_o = load_valid_o ? extData : '0;
    adel_o = excReq & is_load(req_op);
    ades_o = excReq & is_store(req_op);
    badvaddr_o = excReq ? req_addr : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a
// byte-addressed memory model with a READ_LATENCY-deep SRAM.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int RL = 2;
`ifdef MEM_ADDR_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall_o;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic        adel_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastLoad;

  logic [7:0]  mdl  [64];
  logic [31:0] sram [16];
  logic [31:0] pipe [RL];

  mem_access_unit #(
    .READ_LATENCY (RL),
    .ADDR_W       (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .flush           (flush),
    .stall_o         (stall_o),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .load_valid_o    (load_valid_o),
    .load_data_o     (load_data_o),
    .adel_o          (adel_o),
    .ades_o          (ades_o),
    .badvaddr_o      (badvaddr_o)
  );

  always #5 clock = ~clock;

  // SRAM: byte-write, read data valid RL edges after the request.
  always @(posedge clock) begin
    if (data_sram_en) begin
      for (int k = 0; k < 4; k++) begin
        if (data_sram_wen[k]) begin
          sram[data_sram_addr[5:2]][8*k +: 8] <=
            data_sram_wdata[8*k +: 8];
        end
      end
    end
    pipe[0] <= (data_sram_en && data_sram_wen == 4'b0) ?
      sram[data_sram_addr[5:2]] : 32'hDEADBEEF;
    for (int i = 1; i < RL; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign data_sram_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int opSize(input mem_op_t op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction

  function automatic bit misal(input mem_op_t op,
                               input logic [31:0] a);
    return EXC && ((a & 32'(opSize(op) - 1)) != 0);
  endfunction

  function automatic logic [31:0] expLoad(input mem_op_t op,
                                          input logic [31:0] a);
    int sz;
    logic [31:0] ea;
    logic [31:0] v;
    sz = opSize(op);
    ea = a - (a % 32'(sz));
    v = 0;
    for (int i = 0; i < sz; i++) begin
      v = v | (32'(mdl[6'(ea + 32'(i))]) << (8 * i));
    end
    if (op == LB && v[7]) v = v | 32'hFFFFFF00;
    if (op == LH && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // Starts and ends at posedge+1.
  task automatic doStore(input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] d);
    int sz;
    logic [31:0] ea;
    logic [31:0] wd;
    logic [3:0]  wn;
    sz = opSize(op);
    ea = a - (a % 32'(sz));
    wn = 4'((1 << sz) - 1) << ea[1:0];
    wd = (sz == 1) ? d[7:0] * 32'h01010101 :
         (sz == 2) ? d[15:0] * 32'h00010001 : d;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    #3;
    chk("st_stall", stall_o, 0);
    if (misal(op, a)) begin
      chk("ades", ades_o, 1);
      chk("ades_badv", badvaddr_o, a);
      chk("ades_en", {data_sram_en, data_sram_wen}, 0);
    end else begin
      chk("st_en", data_sram_en, 1);
      chk("st_wen", data_sram_wen, wn);
      chk("st_wdata", data_sram_wdata, wd);
      chk("st_addr", data_sram_addr, {a[31:2], 2'b00});
      chk("st_exc", {adel_o, ades_o}, 0);
      chk("st_badv", badvaddr_o, 0);
      for (int i = 0; i < sz; i++) begin
        mdl[6'(ea + 32'(i))] = d[8*i +: 8];
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // flushAt<0: no flush; else flush in that cycle of the access.
  task automatic doLoad(input mem_op_t op, input logic [31:0] a,
                        input int flushAt);
    logic [31:0] exp;
    logic [31:0] gotD;
    int stalls;
    int ens;
    bit got;
    exp = expLoad(op, a);
    stalls = 0;
    ens = 0;
    got = 0;
    gotD = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = $urandom;
    if (misal(op, a)) begin
      #3;
      chk("adel", adel_o, 1);
      chk("adel_badv", badvaddr_o, a);
      chk("adel_en", data_sram_en, 0);
      chk("adel_stall", stall_o, 0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      return;
    end
    for (int c = 0; c < 12 && !got; c++) begin
      flush = (flushAt == c);
      #3;
      if (c == 0) begin
        chk("ld_addr", data_sram_addr, {a[31:2], 2'b00});
        chk("ld_wen", data_sram_wen, 0);
        chk("ld_exc", {adel_o, ades_o}, 0);
      end
      if (stall_o) stalls++;
      if (data_sram_en) ens++;
      if (load_valid_o) begin
        got = 1;
        gotD = load_data_o;
      end
      @(posedge clock);
      #1;
      if (flushAt == c) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    flush = 1'b0;
    chk("ld_en_count", ens, 1);
    if (flushAt < 0) begin
      chk("ld_valid", got, 1);
      chk("ld_data", gotD, exp);
      chk("ld_stalls", stalls, RL + 1);
      lastLoad = gotD;
    end else begin
      chk("fl_no_valid", got, 0);
      chk("fl_stalls", stalls,
          (flushAt < RL + 1) ? flushAt : RL + 1);
    end
  endtask

  initial begin
    int seen;
    mem_op_t op;
    logic [31:0] a;
    int fa;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = SW;
    req_addr  = 32'h10;
    req_wdata = 32'h5;
    flush     = 1'b0;
    lastLoad  = 0;
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("rst_en", {data_sram_en, data_sram_wen}, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", load_valid_o, 0);
    chk("rst_data", load_data_o, 0);
    chk("rst_exc", {adel_o, ades_o}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;

    for (int w = 0; w < 16; w++) begin
      doStore(SW, 32'(w * 4), $urandom);
    end

    doStore(SB, 32'h1003, 32'h000000AB);
    doStore(SW, 32'h2000, 32'h1234F600);
    doLoad(LB, 32'h2001, -1);
    chk("lb_spec", lastLoad, 32'hFFFFFFF6);
    doLoad(LBU, 32'h2001, -1);
    chk("lbu_spec", lastLoad, 32'h000000F6);
    doStore(SW, 32'h2000, 32'h80010000);
    doLoad(LH, 32'h2002, -1);
    chk("lh_spec", lastLoad, 32'hFFFF8001);
    doLoad(LHU, 32'h2002, -1);
    chk("lhu_spec", lastLoad, 32'h00008001);
    doStore(SH, 32'h2, 32'h00005A5A);

    doLoad(LW, 32'h8, 1);
    doStore(SW, 32'hC, 32'hCAFEF00D);
    doLoad(LW, 32'hC, -1);
    chk("lw_after_fl", lastLoad, 32'hCAFEF00D);

    doLoad(LW, 32'h3002, -1);
    doStore(SW, 32'h3001, 32'h11223344);

    req_valid = 1'b1;
    req_op    = LW;
    req_addr  = 32'h4;
    #3;
    chk("rw_req_stall", stall_o, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #3;
    chk("rw_en", {data_sram_en, data_sram_wen}, 0);
    chk("rw_stall", stall_o, 0);
    chk("rw_valid", load_valid_o, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (load_valid_o || stall_o) seen++;
      @(posedge clock);
      #1;
    end
    chk("rw_quiet", seen, 0);
    doStore(SW, 32'h4, 32'h0BADF00D);
    doLoad(LW, 32'h4, -1);
    chk("rw_reload", lastLoad, 32'h0BADF00D);

    for (int n = 0; n < 60; n++) begin
      op = mem_op_t'($urandom_range(0, 7));
      a = $urandom;
      if (is_load(op)) begin
        fa = ($urandom_range(0, 5) == 0) ?
          int'($urandom_range(1, RL + 1)) : -1;
        doLoad(op, a, fa);
      end else begin
        doStore(op, a, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
